// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch sequencer.
package fetch_pkg;

    typedef enum logic [1:0] {
        BOOT,
        FETCH,
        MISS_WAIT,
        JR_WAIT
    } fetch_state_t;

    localparam int unsigned GROUP_SIZE = 4;
    localparam int unsigned GROUP_MASK = GROUP_SIZE - 1;

    // Why the PC moves this cycle; also handy when probing waveforms.
    typedef enum logic [2:0] {
        CAUSE_NONE,
        CAUSE_SEQ,
        CAUSE_MISPREDICT,
        CAUSE_JR,
        CAUSE_JR_EMPTY,
        CAUSE_JAL,
        CAUSE_JUMP,
        CAUSE_BRANCH
    } redirect_cause_t;

    // Every cause other than idle or sequential advance discards the in-flight group.
    function automatic logic is_redirect(redirect_cause_t cause);
        return !(cause inside {CAUSE_NONE, CAUSE_SEQ});
    endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Fetch-side bundle: I-cache handshake, pre-aligner/predictor inputs, redirect and RAS status.
interface fetch_sequencer_if #(
    parameter int unsigned ADDRESS_WIDTH = 22
);
    logic                     i_Stall;
    logic                     o_Fetch_Req;
    logic [ADDRESS_WIDTH-1:0] o_Fetch_Addr;
    logic                     i_Fetch_Ack;
    logic [ADDRESS_WIDTH-1:0] o_pc;
    logic                     i_Align_Valid;
    logic                     i_isbranch;
    logic [ADDRESS_WIDTH-1:0] i_branch_address;
    logic [ADDRESS_WIDTH-1:0] i_Branch_Target;
    logic                     i_j_inst;
    logic                     i_jal_inst;
    logic                     i_jr_inst;
    logic                     i_Predict_Taken;
    logic                     i_Mispredict;
    logic [ADDRESS_WIDTH-1:0] i_Correct_PC;
    logic                     o_Kill;
    logic                     o_RAS_Empty;
    logic                     o_RAS_Overflow;

    modport master (
        input  i_Stall, i_Fetch_Ack, i_Align_Valid, i_isbranch, i_branch_address,
               i_Branch_Target, i_j_inst, i_jal_inst, i_jr_inst, i_Predict_Taken,
               i_Mispredict, i_Correct_PC,
        output o_Fetch_Req, o_Fetch_Addr, o_pc, o_Kill, o_RAS_Empty, o_RAS_Overflow
    );

    modport slave (
        output i_Stall, i_Fetch_Ack, i_Align_Valid, i_isbranch, i_branch_address,
               i_Branch_Target, i_j_inst, i_jal_inst, i_jr_inst, i_Predict_Taken,
               i_Mispredict, i_Correct_PC,
        input  o_Fetch_Req, o_Fetch_Addr, o_pc, o_Kill, o_RAS_Empty, o_RAS_Overflow
    );
endinterface

// File: rtl/fetch_sequencer_ras.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
module return_addr_stack #(
    parameter int unsigned RAS_DEPTH     = 8,
    parameter int unsigned ADDRESS_WIDTH = 22
) (
    input  logic                     i_Clk,
    input  logic                     i_Reset,
    input  logic                     push,
    input  logic [ADDRESS_WIDTH-1:0] push_data,
    input  logic                     pop,
    output logic [ADDRESS_WIDTH-1:0] pop_data,
    output logic                     empty,
    output logic                     overflow
);
    localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [ADDRESS_WIDTH-1:0] mem [RAS_DEPTH];
    logic [PTR_W-1:0]         ptr;
    logic [CNT_W-1:0]         count;

    // Top of stack sits just below the write pointer.
    assign pop_data = mem[ptr - PTR_W'(1)];

    // Entry storage; no reset needed since empty entries are never read.
    always_ff @(posedge i_Clk) begin
        if (push) begin
            mem[ptr] <= push_data;
        end
    end

    // Pointer, occupancy and status flags.
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            ptr      <= '0;
            count    <= '0;
            empty    <= 1'b1;
            overflow <= 1'b0;
        end else if (push) begin
            ptr   <= ptr + PTR_W'(1);
            empty <= 1'b0;
            if (count == CNT_W'(RAS_DEPTH)) begin
                overflow <= 1'b1;
            end else begin
                count <= count + CNT_W'(1);
            end
        end else if (pop) begin
            ptr   <= ptr - PTR_W'(1);
            count <= count - CNT_W'(1);
            empty <= (count == CNT_W'(1));
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch PC owner: sequences 4-word groups and applies redirects from execute and the pre-aligner.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int unsigned              ADDRESS_WIDTH = 22,
    parameter int unsigned              RAS_DEPTH     = 8,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = '0
) (
    input logic               i_Clk,
    input logic               i_Reset,
    fetch_sequencer_if.master bus
);
    fetch_state_t             state;
    redirect_cause_t          cause;
    logic [ADDRESS_WIDTH-1:0] pc_q;
    logic [ADDRESS_WIDTH-1:0] opc_q;
    logic                     req_q;
    logic [ADDRESS_WIDTH-1:0] next_group;
    logic [ADDRESS_WIDTH-1:0] ras_top;
    logic                     ras_empty;
    logic                     ras_overflow;
    logic                     fetching;
    logic                     accept;

    assign fetching   = (state == FETCH) || (state == MISS_WAIT);
    assign accept     = req_q && bus.i_Fetch_Ack;
    assign next_group = (pc_q & ~ADDRESS_WIDTH'(GROUP_MASK)) + ADDRESS_WIDTH'(GROUP_SIZE);

    // Pick this cycle's PC source by priority; pre-aligner redirects only matter while fetching.
    always_comb begin
        cause = CAUSE_NONE;
        if (bus.i_Mispredict) begin
            cause = CAUSE_MISPREDICT;
        end else if (!bus.i_Stall && fetching) begin
            if (bus.i_Align_Valid && bus.i_jr_inst) begin
                cause = ras_empty ? CAUSE_JR_EMPTY : CAUSE_JR;
            end else if (bus.i_Align_Valid && bus.i_jal_inst) begin
                cause = CAUSE_JAL;
            end else if (bus.i_Align_Valid && bus.i_j_inst) begin
                cause = CAUSE_JUMP;
            end else if (bus.i_Align_Valid && bus.i_isbranch && bus.i_Predict_Taken) begin
                cause = CAUSE_BRANCH;
            end else if (accept) begin
                cause = CAUSE_SEQ;
            end
        end
    end

    // Kill must land in the same cycle the redirect is decided, so it stays combinational.
    assign bus.o_Kill         = !i_Reset && is_redirect(cause);
    assign bus.o_Fetch_Req    = req_q;
    assign bus.o_Fetch_Addr   = pc_q;
    assign bus.o_pc           = opc_q;
    assign bus.o_RAS_Empty    = ras_empty;
    assign bus.o_RAS_Overflow = ras_overflow;

    return_addr_stack #(
        .RAS_DEPTH    (RAS_DEPTH),
        .ADDRESS_WIDTH(ADDRESS_WIDTH)
    ) u_ras (
        .i_Clk    (i_Clk),
        .i_Reset  (i_Reset),
        .push     (cause == CAUSE_JAL),
        .push_data(bus.i_branch_address + ADDRESS_WIDTH'(1)),
        .pop      (cause == CAUSE_JR),
        .pop_data (ras_top),
        .empty    (ras_empty),
        .overflow (ras_overflow)
    );

    // Sequencer state, PC and request register.
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            state <= BOOT;
            pc_q  <= RESET_PC;
            opc_q <= RESET_PC;
            req_q <= 1'b0;
        end else begin
            unique case (cause)
                CAUSE_MISPREDICT: begin
                    pc_q  <= bus.i_Correct_PC;
                    state <= FETCH;
                    req_q <= 1'b1;
                end
                CAUSE_JR: begin
                    pc_q  <= ras_top;
                    state <= FETCH;
                    req_q <= 1'b1;
                end
                CAUSE_JR_EMPTY: begin
                    state <= JR_WAIT;
                    req_q <= 1'b0;
                end
                CAUSE_JAL, CAUSE_JUMP, CAUSE_BRANCH: begin
                    pc_q  <= bus.i_Branch_Target;
                    state <= FETCH;
                    req_q <= 1'b1;
                end
                CAUSE_SEQ: begin
                    opc_q <= pc_q;
                    pc_q  <= next_group;
                    state <= FETCH;
                    req_q <= 1'b1;
                end
                CAUSE_NONE: begin
                    if (bus.i_Stall) begin
                        req_q <= 1'b0;
                    end else begin
                        unique case (state)
                            BOOT: begin
                                state <= FETCH;
                                req_q <= 1'b1;
                            end
                            FETCH, MISS_WAIT: begin
                                // A request that was actually presented and not acked is a miss.
                                if (req_q) begin
                                    state <= MISS_WAIT;
                                end
                                req_q <= 1'b1;
                            end
                            JR_WAIT: begin
                                req_q <= 1'b0;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Randomized and directed checks of fetch_sequencer against a queue-based reference model.
module tb_fetch_sequencer;
    localparam int unsigned AW    = 22;
    localparam int unsigned DEPTH = 8;

    logic i_Clk   = 1'b0;
    logic i_Reset = 1'b1;

    always #5 i_Clk = ~i_Clk;

    fetch_sequencer_if #(.ADDRESS_WIDTH(AW)) bus ();

    fetch_sequencer #(
        .ADDRESS_WIDTH(AW),
        .RAS_DEPTH    (DEPTH),
        .RESET_PC     (22'h0)
    ) dut (
        .i_Clk  (i_Clk),
        .i_Reset(i_Reset),
        .bus    (bus)
    );

    // Stimulus for the coming cycle.
    logic          s_stall, s_ack, s_av, s_isbr, s_taken, s_j, s_jal, s_jr, s_mis;
    logic [AW-1:0] s_baddr, s_tgt, s_cpc;

    // Reference model.
    logic [AW-1:0] m_pc, m_opc;
    logic          m_req, m_boot, m_jrwait, m_ovf;
    logic [AW-1:0] m_ras[$];

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic clear_stim();
        s_stall = 1'b0; s_ack = 1'b1; s_av = 1'b0; s_isbr = 1'b0; s_taken = 1'b0;
        s_j = 1'b0; s_jal = 1'b0; s_jr = 1'b0; s_mis = 1'b0;
        s_baddr = '0; s_tgt = '0; s_cpc = '0;
    endtask

    task automatic drive();
        bus.i_Stall          = s_stall;
        bus.i_Fetch_Ack      = s_ack;
        bus.i_Align_Valid    = s_av;
        bus.i_isbranch       = s_isbr;
        bus.i_Predict_Taken  = s_taken;
        bus.i_j_inst         = s_j;
        bus.i_jal_inst       = s_jal;
        bus.i_jr_inst        = s_jr;
        bus.i_Mispredict     = s_mis;
        bus.i_branch_address = s_baddr;
        bus.i_Branch_Target  = s_tgt;
        bus.i_Correct_PC     = s_cpc;
    endtask

    task automatic model_reset();
        m_pc = '0; m_opc = '0; m_req = 1'b0; m_boot = 1'b1; m_jrwait = 1'b0; m_ovf = 1'b0;
        m_ras.delete();
    endtask

    // Apply the priority rules to the model for one clock; returns whether the cycle kills.
    task automatic model_advance(output logic kill);
        kill = 1'b0;
        if (s_mis) begin
            m_pc = s_cpc; m_boot = 1'b0; m_jrwait = 1'b0; m_req = 1'b1; kill = 1'b1;
        end else if (s_stall) begin
            m_req = 1'b0;
        end else if (m_boot) begin
            m_boot = 1'b0; m_req = 1'b1;
        end else if (m_jrwait) begin
            m_req = 1'b0;
        end else if (s_av && s_jr) begin
            kill = 1'b1;
            if (m_ras.size() == 0) begin
                m_jrwait = 1'b1; m_req = 1'b0;
            end else begin
                m_pc = m_ras.pop_back(); m_req = 1'b1;
            end
        end else if (s_av && s_jal) begin
            kill = 1'b1;
            if (m_ras.size() == DEPTH) begin
                m_ras.delete(0); m_ovf = 1'b1;
            end
            m_ras.push_back(s_baddr + AW'(1));
            m_pc = s_tgt; m_req = 1'b1;
        end else if (s_av && (s_j || (s_isbr && s_taken))) begin
            kill = 1'b1; m_pc = s_tgt; m_req = 1'b1;
        end else begin
            if (m_req && s_ack) begin
                m_opc = m_pc;
                m_pc  = (m_pc & ~AW'(3)) + AW'(4);
            end
            m_req = 1'b1;
        end
    endtask

    // One clock: called at a falling edge, returns at the next falling edge.
    task automatic step();
        logic kill_exp;
        check("fetch_addr", 32'(bus.o_Fetch_Addr), 32'(m_pc));
        check("fetch_req", 32'(bus.o_Fetch_Req), 32'(m_req));
        check("o_pc", 32'(bus.o_pc), 32'(m_opc));
        check("ras_empty", 32'(bus.o_RAS_Empty), 32'(m_ras.size() == 0));
        check("ras_overflow", 32'(bus.o_RAS_Overflow), 32'(m_ovf));
        drive();
        #1;
        model_advance(kill_exp);
        check("kill", 32'(bus.o_Kill), 32'(kill_exp));
        @(negedge i_Clk);
    endtask

    initial begin
        clear_stim();
        drive();
        model_reset();
        repeat (3) @(negedge i_Clk);
        check("rst_addr", 32'(bus.o_Fetch_Addr), 32'h0);
        check("rst_req", 32'(bus.o_Fetch_Req), 32'h0);
        check("rst_pc", 32'(bus.o_pc), 32'h0);
        check("rst_kill", 32'(bus.o_Kill), 32'h0);
        check("rst_empty", 32'(bus.o_RAS_Empty), 32'h1);
        check("rst_ovf", 32'(bus.o_RAS_Overflow), 32'h0);
        i_Reset = 1'b0;

        // Sequential groups from reset.
        step();
        check("boot_req", 32'(bus.o_Fetch_Req), 32'h1);
        check("seq0", 32'(bus.o_Fetch_Addr), 32'h0);
        step();
        check("seq4", 32'(bus.o_Fetch_Addr), 32'h4);
        step();
        check("seq8", 32'(bus.o_Fetch_Addr), 32'h8);

        // Miss: hold address 8 for three cycles.
        s_ack = 1'b0;
        repeat (3) step();
        check("miss_addr", 32'(bus.o_Fetch_Addr), 32'h8);
        check("miss_req", 32'(bus.o_Fetch_Req), 32'h1);
        s_ack = 1'b1;
        step();
        check("miss_next", 32'(bus.o_Fetch_Addr), 32'hC);
        check("miss_opc", 32'(bus.o_pc), 32'h8);

        // jal then jr returns to jal address + 1.
        s_av = 1'b1; s_jal = 1'b1; s_baddr = 22'h105; s_tgt = 22'h200;
        step();
        check("jal_tgt", 32'(bus.o_Fetch_Addr), 32'h200);
        clear_stim();
        repeat (2) step();
        s_av = 1'b1; s_jr = 1'b1;
        step();
        check("jr_ret", 32'(bus.o_Fetch_Addr), 32'h106);
        check("jr_empty", 32'(bus.o_RAS_Empty), 32'h1);
        clear_stim();
        step();
        check("jr_unaligned_next", 32'(bus.o_Fetch_Addr), 32'h108);

        // Nine pushes overflow an eight-entry stack; pops come back newest first.
        for (int i = 0; i < 9; i++) begin
            clear_stim();
            s_av = 1'b1; s_jal = 1'b1;
            s_baddr = AW'(32'h1000 + 32'(i) * 32'h10);
            s_tgt   = AW'(32'h3000 + 32'(i) * 32'h40);
            step();
        end
        check("ovf_set", 32'(bus.o_RAS_Overflow), 32'h1);
        for (int i = 0; i < 8; i++) begin
            clear_stim();
            s_av = 1'b1; s_jr = 1'b1;
            step();
            check("pop_order", 32'(bus.o_Fetch_Addr), 32'h1000 + 32'(8 - i) * 32'h10 + 32'h1);
        end
        check("pop_all_empty", 32'(bus.o_RAS_Empty), 32'h1);
        step();
        check("jr_wait_req", 32'(bus.o_Fetch_Req), 32'h0);
        clear_stim();
        repeat (2) step();
        check("jr_wait_hold", 32'(bus.o_Fetch_Req), 32'h0);
        check("ovf_sticky", 32'(bus.o_RAS_Overflow), 32'h1);
        s_mis = 1'b1; s_cpc = 22'h40;
        step();
        check("jr_wait_exit", 32'(bus.o_Fetch_Addr), 32'h40);

        // Mispredict overrides stall; next group wraps to zero.
        clear_stim();
        s_stall = 1'b1; s_mis = 1'b1; s_cpc = 22'h3FFFFC;
        step();
        check("stall_mis", 32'(bus.o_Fetch_Addr), 32'h3FFFFC);
        clear_stim();
        step();
        check("wrap", 32'(bus.o_Fetch_Addr), 32'h0);

        // Mispredict beats a taken branch in the same cycle.
        s_av = 1'b1; s_isbr = 1'b1; s_taken = 1'b1; s_tgt = 22'h40;
        s_mis = 1'b1; s_cpc = 22'h80;
        step();
        check("mis_over_br", 32'(bus.o_Fetch_Addr), 32'h80);

        // Not-taken branch stays sequential without a kill.
        clear_stim();
        s_av = 1'b1; s_isbr = 1'b1; s_taken = 1'b0; s_tgt = 22'h1234;
        step();
        check("nt_branch", 32'(bus.o_Fetch_Addr), 32'h84);

        // Random traffic.
        for (int n = 0; n < 800; n++) begin
            int kind;
            clear_stim();
            s_mis   = ($urandom_range(0, 19) == 0);
            s_stall = ($urandom_range(0, 7) == 0);
            s_ack   = ($urandom_range(0, 9) < 7);
            s_av    = ($urandom_range(0, 2) == 0);
            kind    = int'($urandom_range(0, 4));
            s_j     = (kind == 1);
            s_jal   = (kind == 2);
            s_jr    = (kind == 3);
            s_isbr  = (kind == 4);
            s_taken = $urandom_range(0, 1) == 1;
            s_baddr = AW'($urandom);
            s_tgt   = ($urandom_range(0, 3) == 0) ? AW'(22'h3FFFF0 | AW'($urandom_range(0, 15)))
                                                  : AW'($urandom);
            s_cpc   = AW'($urandom);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
